sw_capture: RTL

Switch input capture port between the board switches and the picoMIPS datapath. It synchronises the `SW` bus and debounces a user strobe switch. On each qualified press it latches the data switches into a holding register and presents them to the datapath through a valid/ack handshake, so the CPU reads one stable operand per press instead of raw switch levels.

---
 rtl/sw_capture_pkg.sv | 16 +
 rtl/sw_debounce.sv | 44 ++++
 rtl/sw_capture.sv | 119 +++++++++++
 3 files changed

// File: rtl/sw_capture_pkg.sv
// Shared constants and types for the switch capture port (the cpuConfig additions):
// default widths, switch bit positions and the capture FSM state type.
package sw_capture_pkg;

    localparam int SWCAP_N         = 8;
    localparam int SWCAP_DB_CYCLES = 16;
    localparam int SW_W            = 10;
    localparam int SW_STROBE       = 8;
    localparam int SW_ENABLE       = 9;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } swcapState_t;

endpackage

// File: rtl/sw_debounce.sv
// 1-bit debouncer: the output level follows the input only after DB_CYCLES
// consecutive mismatched cycles. Rise/fall pulses flag the edge on which it toggles.
module sw_debounce
    import sw_capture_pkg::*;
#(
    parameter int DB_CYCLES = SWCAP_DB_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_rise,
    output logic o_fall
);

    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_db;
    logic          w_mismatch;
    logic          w_toggle;

    assign w_mismatch = i_in ^ r_db;
    assign w_toggle   = w_mismatch && (r_cnt == CNT_LAST);

    // The counter only runs while mismatched and clears on the toggle, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (!w_mismatch) begin
            r_cnt <= '0;
        end else if (w_toggle) begin
            r_db  <= ~r_db;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_rise = w_toggle & ~r_db;
    assign o_fall = w_toggle &  r_db;

endmodule

// File: rtl/sw_capture.sv
// Switch capture port: synchronises SW, debounces the strobe and latches one operand per press.
// Optional sticky overrun flag when SWCAP_OVERRUN_EN is defined.
module sw_capture
    import sw_capture_pkg::*;
#(
    parameter int N         = SWCAP_N,
    parameter int DB_CYCLES = SWCAP_DB_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SW_W-1:0] SW,
    output logic [N-1:0]    sw_level,
    output logic [N-1:0]    data_out,
    output logic            data_valid,
    input  logic            data_ack
`ifdef SWCAP_OVERRUN_EN
    ,
    output logic            overrun
`endif
);

    logic [SW_W-1:0] r_sync1;
    logic [SW_W-1:0] r_sync2;
    logic [N-1:0]    r_data;
    logic            r_valid;
    swcapState_t     r_state;
    swcapState_t     w_state_nxt;
    logic            w_rise;
    logic            w_fall;
    logic            w_attempt;
    logic            w_load;
    logic            w_clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= SW;
            r_sync2 <= r_sync1;
        end
    end

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .i_in   (r_sync2[SW_STROBE]),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A press with enable low still moves to HELD so the held strobe cannot capture later.
    always_comb begin
        w_state_nxt = r_state;
        w_attempt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HELD;
                    w_attempt   = r_sync2[SW_ENABLE];
                end
            end
            HELD: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A capture coinciding with ack wins: the slot is freed and refilled on the same edge.
    assign w_load  = w_attempt && (!r_valid || data_ack);
    assign w_clear = data_ack && r_valid && !w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= r_sync2[N-1:0];
            r_valid <= 1'b1;
        end else if (w_clear) begin
            r_valid <= 1'b0;
        end
    end

`ifdef SWCAP_OVERRUN_EN
    logic r_overrun;
    logic w_drop;

    assign w_drop = w_attempt && r_valid && !data_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

    assign sw_level   = r_sync2[N-1:0];
    assign data_out   = r_data;
    assign data_valid = r_valid;

endmodule
